// File: rtl/dragon_head_ctrl.sv
// -----------------------------------------------------------------------------
// dragon_head_ctrl
//
// Upstream stage of the dragon body segment queue. Produces the dragon head
// word (orientation + grid position), a frame-based movement counter, and
// one-cycle length-update pulses consumed by the body stage.
//
// The head takes one grid step toward target_pos every MOVE_PERIOD+1 frames
// (x axis first, then y). A saturating length count keeps grow/shrink pulses
// consistent with the body length limit.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-low reset
//   vsync            frame sync level; a rising edge is one frame tick
//   target_pos       chase target, [7:4] x, [3:0] y, sampled in S_DECIDE
//   heal_event       single-cycle grow request
//   hit_event        single-cycle shrink request
//   dragon_head      [9:8] orientation (00 up, 01 right, 10 down, 11 left),
//                    [7:0] position
//   movement_counter frame counter 0..MOVE_PERIOD
//   length_update    00 none, 01 heal, 10 hit (registered, 1-clk latency)
//   dragon_len       current body length 0..MAX_LEN
//   step_pulse       high for the one clk in which dragon_head takes its new
//                    value
// -----------------------------------------------------------------------------
module dragon_head_ctrl #(
  parameter int unsigned MOVE_PERIOD = 10,
  parameter logic [7:0]  START_POS   = 8'h00,
  parameter int unsigned MAX_LEN     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [7:0] target_pos,
  input  logic       heal_event,
  input  logic       hit_event,
  output logic [9:0] dragon_head,
  output logic [5:0] movement_counter,
  output logic [1:0] length_update,
  output logic [2:0] dragon_len,
  output logic       step_pulse
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'b00,
    S_DECIDE = 2'b01,
    S_UPDATE = 2'b10
  } state_e;

  // Encoding matches the orientation field of dragon_head.
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    LU_NONE = 2'b00,
    LU_HEAL = 2'b01,
    LU_HIT  = 2'b10
  } len_upd_e;

  localparam logic [5:0] MOVE_PERIOD_C = 6'(MOVE_PERIOD);
  localparam logic [2:0] MAX_LEN_C     = 3'(MAX_LEN);
  localparam logic [9:0] HEAD_RESET    = {2'b00, START_POS};

  state_e     state_q,   state_d;
  logic       vsync_d_q, vsync_d_d;
  logic [5:0] counter_q, counter_d;
  logic [9:0] head_q,    head_d;
  dir_e       dir_q,     dir_d;
  logic       move_q,    move_d;
  logic       step_q,    step_d;
  len_upd_e   len_upd_q, len_upd_d;
  logic [2:0] len_q,     len_d;

  logic       frame_tick;
  logic [3:0] head_x, head_y, tgt_x, tgt_y;

  assign frame_tick = vsync & ~vsync_d_q;
  assign head_x     = head_q[7:4];
  assign head_y     = head_q[3:0];
  assign tgt_x      = target_pos[7:4];
  assign tgt_y      = target_pos[3:0];

  // ---------------------------------------------------------------------------
  // Movement FSM: count frames, decide a direction, then apply the step.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d   = state_q;
    vsync_d_d = vsync;
    counter_d = counter_q;
    head_d    = head_q;
    dir_d     = dir_q;
    move_d    = move_q;
    step_d    = 1'b0;

    unique case (state_q)
      S_WAIT: begin
        // Ticks are only counted here; the two-cycle decide/update window is
        // far shorter than a frame, so no tick is ever lost in practice.
        if (frame_tick) begin
          if (counter_q == MOVE_PERIOD_C) begin
            counter_d = '0;
            state_d   = S_DECIDE;
          end else begin
            counter_d = counter_q + 6'd1;
          end
        end
      end

      S_DECIDE: begin
        // x axis has priority over y; equal position means no move.
        move_d = 1'b1;
        if (tgt_x > head_x)      dir_d = DIR_RIGHT;
        else if (tgt_x < head_x) dir_d = DIR_LEFT;
        else if (tgt_y > head_y) dir_d = DIR_DOWN;
        else if (tgt_y < head_y) dir_d = DIR_UP;
        else                     move_d = 1'b0;
        state_d = S_UPDATE;
      end

      S_UPDATE: begin
        // Moves always head toward the target, so a coordinate can never
        // step past 0 or 15 and no wrap handling is needed.
        if (move_q) begin
          head_d[9:8] = dir_q;
          unique case (dir_q)
            DIR_UP:    head_d[3:0] = head_y - 4'd1;
            DIR_RIGHT: head_d[7:4] = head_x + 4'd1;
            DIR_DOWN:  head_d[3:0] = head_y + 4'd1;
            DIR_LEFT:  head_d[7:4] = head_x - 4'd1;
          endcase
          step_d = 1'b1;
        end
        state_d = S_WAIT;
      end

      default: state_d = S_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Length tracking: independent of the movement FSM. Simultaneous heal and
  // hit cancel; requests beyond the limits are dropped without a pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    len_upd_d = LU_NONE;
    len_d     = len_q;
    if (heal_event && !hit_event && (len_q < MAX_LEN_C)) begin
      len_upd_d = LU_HEAL;
      len_d     = len_q + 3'd1;
    end else if (hit_event && !heal_event && (len_q != 3'd0)) begin
      len_upd_d = LU_HIT;
      len_d     = len_q - 3'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    // Reset is synchronous: it is just another input sampled at the edge, so
    // an in-flight step is aborted and no step_pulse can escape.
    if (!reset) begin
      state_q   <= S_WAIT;
      vsync_d_q <= 1'b0;
      counter_q <= '0;
      head_q    <= HEAD_RESET;
      dir_q     <= DIR_UP;
      move_q    <= 1'b0;
      step_q    <= 1'b0;
      len_upd_q <= LU_NONE;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      vsync_d_q <= vsync_d_d;
      counter_q <= counter_d;
      head_q    <= head_d;
      dir_q     <= dir_d;
      move_q    <= move_d;
      step_q    <= step_d;
      len_upd_q <= len_upd_d;
      len_q     <= len_d;
    end
  end

  assign dragon_head      = head_q;
  assign movement_counter = counter_q;
  assign length_update    = len_upd_q;
  assign dragon_len       = len_q;
  assign step_pulse       = step_q;

endmodule

// File: doc/dragon_head_ctrl.md
Name: dragon_head_ctrl

Overview:
Upstream stage of the dragon body segment queue. Generates the dragon head word (orientation plus grid position), the frame-based movement counter, and the one-cycle length-update pulses that the body stage consumes. The head steps one grid cell toward a target position every MOVE_PERIOD+1 frames. A saturating length count keeps grow/shrink pulses consistent with the 7-segment body limit.

Parameters:
MOVE_PERIOD, 10, movement_counter terminal value; head steps when a frame tick arrives with counter == MOVE_PERIOD (legal range 1..63)
START_POS, 8'h00, head position after reset ([7:4] x, [3:0] y)
MAX_LEN, 7, maximum body length; dragon_len saturates here (legal range 1..7)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
vsync  input  1  frame sync level, sampled on clk; rising edge = frame tick
target_pos  input  8  chase target, [7:4] x, [3:0] y, sampled in S_DECIDE
heal_event  input  1  single-cycle grow request
hit_event  input  1  single-cycle shrink request
dragon_head  output  10  [9:8] orientation (00 up, 01 right, 10 down, 11 left), [7:0] position
movement_counter  output  6  frame counter 0..MOVE_PERIOD
length_update  output  2  00 none, 01 HEAL, 10 HIT; 11 never driven
dragon_len  output  3  current body length 0..MAX_LEN
step_pulse  output  1  high for one clk when dragon_head changes position/orientation

Behaviour:
- Reset is synchronous, active-low: reset==0 at a clk edge forces all state and outputs to reset values.
- Reset values: dragon_head = {2'b00, START_POS}; movement_counter = 0; length_update = 00; dragon_len = 0; step_pulse = 0; FSM = S_WAIT; vsync_d = 0.
- Frame tick: frame_tick = vsync & ~vsync_d, where vsync_d is a one-clk registered copy of vsync. One tick per vsync rising edge, regardless of how long vsync stays high.
- FSM:
  - S_WAIT: on frame_tick:
    - counter < MOVE_PERIOD: counter += 1, stay in S_WAIT.
    - counter == MOVE_PERIOD: counter <= 0, go to S_DECIDE.
  - S_DECIDE (1 clk): compare target_pos with head position and register the direction.
    - Priority: x before y.
    - tx > hx: right. tx < hx: left.
    - Else ty > hy: down. ty < hy: up.
    - Else: no move.
  - S_UPDATE (1 clk):
    - Move: apply ±1 to the chosen axis, set orientation to the chosen direction, assert step_pulse for this cycle.
    - No move: head unchanged, step_pulse stays 0.
    - Next state: S_WAIT.
- Frame ticks arriving in S_DECIDE or S_UPDATE are not counted. This is acceptable because a frame is much longer than 2 clk.
- Wrap-around: none on position. Moves are always toward the target, so a coordinate never passes 0 or 15.
- movement_counter therefore holds MOVE_PERIOD for exactly one full frame interval. The downstream stage shifts on the vsync edge at which it observes MOVE_PERIOD.
- Length pulses: registered with 1-clk latency. An event in cycle N gives length_update valid in cycle N+1 only.
  - heal_event alone with dragon_len < MAX_LEN: length_update = 01, dragon_len += 1.
  - hit_event alone with dragon_len > 0: length_update = 10, dragon_len -= 1.
  - Saturation: heal at MAX_LEN, or hit at 0, gives length_update = 00 and dragon_len unchanged.
  - heal_event and hit_event in the same cycle: both dropped, length_update = 00.
  - Back-to-back events in consecutive cycles each produce their own pulse in consecutive cycles.
  - length_update is independent of the movement FSM; pulses may coincide with step_pulse.
- Reset mid-operation: reset asserted in S_DECIDE or S_UPDATE aborts the step. Head returns to START_POS and no step_pulse is generated. A pending length pulse is cleared.

Test Plan:
- Reset: hold reset=0 for 3 clk with vsync toggling and events active -> dragon_head=10'h000, counter=0, length_update=00, dragon_len=0, step_pulse=0.
- Counter: reset release, MOVE_PERIOD=10, 12 vsync rising edges, vsync held high 50 clk each -> counter reads 1..10, then 0 on the 11th edge. Exactly one step_pulse, 2 clk after the 11th edge.
- Chase: START_POS=8'h00, target_pos=8'h21 -> successive heads 0x110, 0x120, 0x221 (right, right, down). Further periods give no step_pulse and the head stays 0x221.
- Leftward/up: head at 0x33, target 0x13 -> 0x323 then 0x313. Head at 0x13 with target 0x10 -> up moves to 0x012, 0x011, 0x010.
- Length: 8 heal pulses -> seven 01 pulses, 8th gives 00, dragon_len=7. Then 8 hit pulses -> seven 10 pulses, dragon_len=0, 8th gives 00.
- Simultaneous and abort: heal and hit in the same cycle -> 00, len unchanged. reset=0 during S_UPDATE -> head=START_POS, step_pulse stays 0.
